bit_packer: RTL and testbench
=============================

# bit_packer

Parametrised successor to the IVN output buffer. Accepts up to `LANES` debiased bits per cycle from the per-lane IVN extractors, compacts the valid ones in lane order, and queues them in a `DEPTH`-bit shift buffer. It emits `OUT_W`-bit words over a valid/ready handshake. When the buffer is full it drops excess bits, counts them in a saturating drop counter and sets a sticky overflow flag. It sits between the IVN array and the downstream consumer (serial pin, LFSR seeder or bus).

## Interface
- `LANES`, 6, number of input lanes (≥1)
- `OUT_W`, 16, output word width in bits (≥1; `OUT_W`=1 gives serial mode)
- `DEPTH`, 64, buffer capacity in bits; must satisfy `DEPTH` ≥ `OUT_W`+`LANES` (elaboration-time check, fatal)
- `CNT_W`, 16, drop counter width
- `clk`  in  1  clock, all logic on rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `in_valid`  in  `LANES`  per-lane bit-valid
- `in_bits`  in  `LANES`  per-lane bit value; ignored where `in_valid`=0
- `out_ready`  in  1  consumer accepts word this cycle
- `out_valid`  out  1  at least `OUT_W` bits buffered
- `out_data`  out  `OUT_W`  oldest `OUT_W` bits; oldest bit in `out_data[0]`
- `fill`  out  $clog2(`DEPTH`+1)  bits currently buffered
- `overflow`  out  1  sticky; set on any dropped bit
- `drop_count`  out  `CNT_W`  total dropped bits, saturating at all-ones
- `clear_stats`  in  1  clears `overflow` and `drop_count`

## Operation
- Compaction: the k = popcount(`in_valid`) valid bits are ordered by ascending lane index, so lane 0 is the oldest. Gaps are removed.
- Pop: `pop` = `out_valid` && `out_ready`. On pop, buffer shifts down `OUT_W` bits and `fill` decreases by `OUT_W`.
- Push: compacted bits are appended at position `fill` − (`pop` ? `OUT_W` : 0). Push and pop in the same cycle are both honoured.
- Space: `space` = `DEPTH` − `fill` + (`pop` ? `OUT_W` : 0). Accept min(k, `space`) bits, taking the first ones in compacted order. Drop the remainder.
- Drops: `drop_count` += dropped, saturating at 2^`CNT_W`−1. `overflow` is set if dropped > 0.
- `clear_stats`: zeroes both stats next cycle. If a drop occurs in the same cycle, `drop_count` = that cycle's dropped count and `overflow` = 1 (the drop wins over the clear).
- Buffer bits at index ≥ `fill` are always 0.
- `out_valid` = (`fill` ≥ `OUT_W`), decoded from registered `fill`. There is no combinational path from any input to any output.
- `out_data` is held stable while `out_valid` && !`out_ready`, because pushes only write positions ≥ `OUT_W`.
- No FSM beyond `fill`. Behaviour is fully determined by the `fill`, buffer and stats registers.

## Timing
- Reset (`reset_n`=0 at an edge): buffer = 0, `fill` = 0, `out_valid` = 0, `out_data` = 0, `overflow` = 0, `drop_count` = 0. Reset mid-operation discards all buffered bits and stats; the handshake restarts cleanly.
- Latency: a bit presented at edge t is visible in `out_data` after edge t at the earliest, i.e. one cycle.
- Throughput: one word per cycle while `fill` ≥ `OUT_W`. Sustained input of `LANES` bits/cycle needs `OUT_W` ≥ `LANES` to avoid loss.
- `fill` never exceeds `DEPTH`. Arithmetic uses $clog2(`DEPTH`+1)+1 bits internally to avoid wrap.

## Structure
- Shared package `trng_pkg`:
  - `FILL_W(depth)` function
  - default `LANES`/`OUT_W`/`DEPTH` constants shared with `ivn_top`
- Sub-module `lane_compactor` (combinational, parametrised by `LANES`): outputs the compacted bit vector and popcount k.
- `bit_packer` contains:
  - buffer register
  - `fill`/space arithmetic
  - masked append
  - stats counters

## Test plan
- Reset, then `in_valid`=6'b000101, `in_bits`=6'b000100 (LANES=6, OUT_W=4): after 1 edge `fill`=2, buffer[1:0]=2'b10 (lane 0 bit = 0 at [0], lane 2 bit = 1 at [1]), `out_valid`=0.
- Two more cycles of all-valid `in_bits`=6'b111111 with `out_ready`=0: `fill`=14, `out_valid`=1, `out_data`=4'b1110; `out_data` unchanged after a further 3 idle cycles.
- Simultaneous: `fill`=14, `out_ready`=1, 6 valid bits → `fill`=16, next `out_data` = buffer[7:4] of the prior state.
- DEPTH=16, `fill`=14, `out_ready`=0, 6 valid bits: 2 accepted, `fill`=16, `drop_count`=4, `overflow`=1. `clear_stats` plus 3 more drops in the same cycle → `drop_count`=3, `overflow`=1.
- CNT_W=4, force 20 drops: `drop_count` saturates at 15.
- OUT_W=1, `out_ready`=1 constant, random stream: serial output equals the compacted input sequence, bit-exact.
- Assert `reset_n`=0 with `fill`=10: next cycle all outputs = 0.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared TRNG-path constants and helpers used by the IVN array and the bit packer.
package trng_pkg;

  localparam int unsigned DEF_LANES = 6;
  localparam int unsigned DEF_OUT_W = 16;
  localparam int unsigned DEF_DEPTH = 64;
  localparam int unsigned DEF_CNT_W = 16;

  // Width needed to hold a bit count in the range 0..depth inclusive.
  function automatic int unsigned FILL_W(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lane_compactor.sv
// Gathers the valid lane bits into a gap-free vector, lane 0 landing at bit 0,
// and reports how many bits were valid.
module lane_compactor
  import trng_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  localparam int unsigned K_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0] in_valid,
  input  logic [LANES-1:0] in_bits,
  output logic [LANES-1:0] comp_bits,
  output logic [K_W-1:0]   count
);

  always_comb begin
    comp_bits = '0;
    count     = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (in_valid[i]) begin
        comp_bits = comp_bits | (LANES'(in_bits[i]) << count);
        count     = count + K_W'(1);
      end
    end
  end

endmodule

// File: rtl/bit_packer.sv
// Compacts valid lane bits into a DEPTH-bit shift buffer and emits OUT_W-bit
// words over valid/ready; excess bits are dropped and counted.
module bit_packer
  import trng_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES-1:0]           in_bits,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           out_data,
  output logic [FILL_W(DEPTH)-1:0]   fill,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count,
  input  logic                       clear_stats
);

  localparam int unsigned FW = FILL_W(DEPTH);
  localparam int unsigned AW = FW + 1;
  localparam int unsigned KW = $clog2(LANES + 1);
  localparam int unsigned SW = ((CNT_W > KW) ? CNT_W : KW) + 1;

  if (LANES < 1 || OUT_W < 1 || DEPTH < OUT_W + LANES) begin : g_param_check
    $fatal(1, "bit_packer: need LANES>=1, OUT_W>=1 and DEPTH >= OUT_W + LANES");
  end

  logic [DEPTH-1:0] shift_buf;
  logic [DEPTH-1:0] buf_shifted;
  logic [DEPTH-1:0] buf_d;
  logic [LANES-1:0] comp_bits;
  logic [LANES-1:0] keep_bits;
  logic [KW-1:0]    k;
  logic [KW-1:0]    accepted;
  logic [KW-1:0]    dropped;
  logic             pop;
  logic [AW-1:0]    base;
  logic [AW-1:0]    space;
  logic [AW-1:0]    k_x;
  logic [AW-1:0]    acc_x;
  logic [FW-1:0]    fill_d;
  logic [SW-1:0]    stat_base;
  logic [SW-1:0]    stat_sum;
  logic [CNT_W-1:0] drop_d;
  logic             overflow_d;

  lane_compactor #(
    .LANES(LANES)
  ) u_compactor (
    .in_valid  (in_valid),
    .in_bits   (in_bits),
    .comp_bits (comp_bits),
    .count     (k)
  );

  // Outputs decode only registered state, so no input reaches an output combinationally.
  assign out_valid = (fill >= FW'(OUT_W));
  assign out_data  = shift_buf[OUT_W-1:0];
  assign pop       = out_valid && out_ready;

  always_comb begin
    base     = AW'(fill) - (pop ? AW'(OUT_W) : '0);
    space    = AW'(DEPTH) - base;
    k_x      = AW'(k);
    acc_x    = (k_x < space) ? k_x : space;
    accepted = KW'(acc_x);
    dropped  = k - accepted;

    // Only the first 'accepted' compacted bits survive; bits above fill stay zero.
    keep_bits   = comp_bits & ~({LANES{1'b1}} << accepted);
    buf_shifted = pop ? (shift_buf >> OUT_W) : shift_buf;
    buf_d       = buf_shifted | (DEPTH'(keep_bits) << base);
    fill_d      = FW'(base + acc_x);

    // A drop in the same cycle as clear_stats survives the clear.
    stat_base  = clear_stats ? '0 : SW'(drop_count);
    stat_sum   = stat_base + SW'(dropped);
    drop_d     = (stat_sum > SW'({CNT_W{1'b1}})) ? '1 : CNT_W'(stat_sum);
    overflow_d = (overflow && !clear_stats) || (dropped != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_buf  <= '0;
      fill       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      shift_buf  <= buf_d;
      fill       <= fill_d;
      overflow   <= overflow_d;
      drop_count <= drop_d;
    end
  end

endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: a queue-based model of the packer plus directed literal
// expectations (instance A) and a serial bit-exact stream check (instance B).
module tb_bit_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A: LANES=6, OUT_W=4, DEPTH=16, CNT_W=4
  logic       rst_a = 1'b0;
  logic [5:0] a_valid = '0, a_bits = '0;
  logic       a_ready = 1'b0, a_clear = 1'b0;
  logic       a_ov, a_ovf;
  logic [3:0] a_data, a_dc;
  logic [4:0] a_fill;

  bit_packer #(.LANES(6), .OUT_W(4), .DEPTH(16), .CNT_W(4)) u_a (
    .clk(clk), .reset_n(rst_a), .in_valid(a_valid), .in_bits(a_bits),
    .out_ready(a_ready), .out_valid(a_ov), .out_data(a_data), .fill(a_fill),
    .overflow(a_ovf), .drop_count(a_dc), .clear_stats(a_clear)
  );

  // Instance B: serial mode
  logic        rst_b = 1'b0;
  logic [5:0]  b_valid = '0, b_bits = '0;
  logic        b_ready = 1'b1, b_clear = 1'b0;
  logic        b_ov, b_ovf;
  logic [0:0]  b_data;
  logic [15:0] b_dc;
  logic [4:0]  b_fill;

  bit_packer #(.LANES(6), .OUT_W(1), .DEPTH(16), .CNT_W(16)) u_b (
    .clk(clk), .reset_n(rst_b), .in_valid(b_valid), .in_bits(b_bits),
    .out_ready(b_ready), .out_valid(b_ov), .out_data(b_data), .fill(b_fill),
    .overflow(b_ovf), .drop_count(b_dc), .clear_stats(b_clear)
  );

  // Model of A: the buffer is a FIFO of bits, stats are plain integers.
  bit qa[$];
  int dca = 0;
  bit ova = 1'b0;
  int nd;
  bit cmp_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_a) begin
      qa.delete();
      dca = 0;
      ova = 1'b0;
    end else begin
      nd = 0;
      if (qa.size() >= 4 && a_ready) repeat (4) void'(qa.pop_front());
      for (int i = 0; i < 6; i++)
        if (a_valid[i]) begin
          if (qa.size() < 16) qa.push_back(a_bits[i]);
          else nd++;
        end
      if (a_clear) begin
        dca = 0;
        ova = 1'b0;
      end
      dca = dca + nd;
      if (dca > 15) dca = 15;
      if (nd > 0) ova = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0] e;
      e = '0;
      for (int i = 0; i < 4; i++) if (i < qa.size()) e[i] = qa[i];
      check("a_fill", 64'(a_fill), 64'(qa.size()));
      check("a_out_valid", 64'(a_ov), 64'(qa.size() >= 4));
      check("a_out_data", 64'(a_data), 64'(e));
      check("a_overflow", 64'(a_ovf), 64'(ova));
      check("a_drop_count", 64'(a_dc), 64'(dca));
    end
  end

  // Serial scoreboard for B: every popped bit must be the next compacted input bit.
  bit exp_ser[$];
  bit b_done = 1'b0;

  always @(negedge clk) begin
    if (rst_b && b_ov) begin
      if (exp_ser.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ser_bit actual=%0b required=none(queue empty)", b_data);
      end else begin
        check("ser_bit", 64'(b_data), 64'(exp_ser.pop_front()));
      end
    end
  end

  initial begin : stim_b
    int r;
    logic [5:0] v, bb;
    tick();
    tick();
    rst_b = 1'b1;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      v = '0;
      if (r >= 4) v[$urandom_range(0, 5)] = 1'b1;
      if (r >= 8) v[$urandom_range(0, 5)] = 1'b1;
      bb = 6'($urandom);
      b_valid = v;
      b_bits  = bb;
      for (int i = 0; i < 6; i++) if (v[i]) exp_ser.push_back(bb[i]);
      tick();
    end
    b_valid = '0;
    for (int n = 0; n < 100 && exp_ser.size() != 0; n++) tick();
    tick();
    check("ser_drain_left", 64'(exp_ser.size()), 64'd0);
    check("ser_fill_empty", 64'(b_fill), 64'd0);
    check("ser_drop_count", 64'(b_dc), 64'd0);
    check("ser_overflow", 64'(b_ovf), 64'd0);
    b_done = 1'b1;
  end

  initial begin : stim_a
    tick();
    tick();
    check("rst_fill", 64'(a_fill), 64'd0);
    check("rst_out_valid", 64'(a_ov), 64'd0);
    check("rst_out_data", 64'(a_data), 64'd0);
    check("rst_overflow", 64'(a_ovf), 64'd0);
    check("rst_drop_count", 64'(a_dc), 64'd0);
    rst_a  = 1'b1;
    cmp_en = 1'b1;

    a_valid = 6'b000101; a_bits = 6'b000100; a_ready = 1'b0;
    tick();
    check("t1_fill", 64'(a_fill), 64'd2);
    check("t1_data", 64'(a_data), 64'h2);
    check("t1_out_valid", 64'(a_ov), 64'd0);

    a_valid = 6'b111111; a_bits = 6'b111111;
    tick();
    tick();
    check("t2_fill", 64'(a_fill), 64'd14);
    check("t2_out_valid", 64'(a_ov), 64'd1);
    check("t2_data", 64'(a_data), 64'he);
    a_valid = '0;
    repeat (3) tick();
    check("t2_data_held", 64'(a_data), 64'he);

    a_valid = 6'b111111; a_bits = 6'b010110; a_ready = 1'b1;
    tick();
    check("t3_fill", 64'(a_fill), 64'd16);
    check("t3_data", 64'(a_data), 64'hf);

    a_valid = 6'b000011; a_bits = 6'b000001;
    tick();
    check("t4_fill_pre", 64'(a_fill), 64'd14);
    a_ready = 1'b0; a_valid = 6'b111111; a_bits = 6'b101010;
    tick();
    check("t4_fill", 64'(a_fill), 64'd16);
    check("t4_drop_count", 64'(a_dc), 64'd4);
    check("t4_overflow", 64'(a_ovf), 64'd1);
    a_clear = 1'b1; a_valid = 6'b000111;
    tick();
    check("t4_clear_drop", 64'(a_dc), 64'd3);
    check("t4_clear_ovf", 64'(a_ovf), 64'd1);
    a_valid = '0;
    tick();
    check("t4_clear_only_dc", 64'(a_dc), 64'd0);
    check("t4_clear_only_ovf", 64'(a_ovf), 64'd0);
    a_clear = 1'b0;

    a_valid = 6'b111111;
    repeat (3) tick();
    a_valid = 6'b000011;
    tick();
    check("t5_saturate", 64'(a_dc), 64'd15);

    a_ready = 1'b1; a_valid = 6'b000011;
    tick();
    a_valid = '0;
    tick();
    a_ready = 1'b0;
    check("t6_fill_pre", 64'(a_fill), 64'd10);
    rst_a = 1'b0;
    tick();
    check("t6_fill", 64'(a_fill), 64'd0);
    check("t6_out_valid", 64'(a_ov), 64'd0);
    check("t6_out_data", 64'(a_data), 64'd0);
    check("t6_overflow", 64'(a_ovf), 64'd0);
    check("t6_drop_count", 64'(a_dc), 64'd0);
    rst_a = 1'b1;

    for (int n = 0; n < 80; n++) begin
      a_valid = 6'($urandom);
      a_bits  = 6'($urandom);
      a_ready = 1'($urandom_range(0, 1));
      a_clear = ($urandom_range(0, 15) == 0);
      tick();
    end
    a_valid = '0;
    a_clear = 1'b0;

    for (int n = 0; n < 2000 && !b_done; n++) tick();
    check("b_done", 64'(b_done), 64'd1);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
